// File: rtl/vga_timing_monitor.sv
// rtl/vga_timing_monitor.sv - VGA sync timing measurement and lock monitor
// The optional err_cnt lock-loss counter is built only when VGA_MON_ERR_CNT_EN is defined.
module vga_timing_monitor #(
  parameter int HW         = 12,
  parameter int VW         = 11,
  parameter int LOCK_LINES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vga_h_sync,
  input  logic          vga_v_sync,
  output logic          line_start,
  output logic          frame_start,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_sync_w,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_sync_w,
  output logic          locked,
  output logic [7:0]    err_cnt
);

  localparam int SW = $clog2(LOCK_LINES + 1) + 1;
  localparam logic [SW-1:0] LOCK_TH = SW'(LOCK_LINES);

  // Synchronizer stages; stage 3 is the previous synchronized value for edge detect.
  logic hs_s1_q, hs_s2_q, hs_s3_q;
  logic vs_s1_q, vs_s2_q, vs_s3_q;

  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          h_seen_q, h_seen_d;
  logic [HW-1:0] h_total_q, h_total_d;
  logic [HW-1:0] hlow_q, hlow_d;
  logic          h_fell_q, h_fell_d;
  logic [HW-1:0] h_sync_w_q, h_sync_w_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          v_seen_q, v_seen_d;
  logic [VW-1:0] v_total_q, v_total_d;
  logic [VW-1:0] v_prev_q, v_prev_d;
  logic [VW-1:0] vlow_q, vlow_d;
  logic          v_fell_q, v_fell_d;
  logic [VW-1:0] v_sync_w_q, v_sync_w_d;
  logic [SW-1:0] stable_q, stable_d;
  logic          locked_q, locked_d;

  logic          hs_fall, hs_rise, vs_fall, vs_rise;
  logic          h_sat, h_latch, v_latch;
  logic [HW-1:0] h_meas;

  always_comb begin
    hs_fall = hs_s3_q & ~hs_s2_q;
    hs_rise = ~hs_s3_q & hs_s2_q;
    vs_fall = vs_s3_q & ~vs_s2_q;
    vs_rise = ~vs_s3_q & vs_s2_q;

    h_sat   = (hcnt_q == '1);
    h_meas  = hcnt_q + HW'(1);
    h_latch = line_start_q & h_seen_q & ~h_sat;
    v_latch = frame_start_q & v_seen_q;

    line_start_d  = hs_fall;
    frame_start_d = vs_fall;

    // Horizontal period measurement with saturation timeout
    hcnt_d    = hcnt_q;
    h_seen_d  = h_seen_q;
    h_total_d = h_total_q;
    stable_d  = stable_q;
    if (line_start_q) begin
      hcnt_d   = '0;
      h_seen_d = 1'b1;
    end else if (!h_sat) begin
      hcnt_d = hcnt_q + HW'(1);
    end else begin
      h_seen_d = 1'b0;
    end
    if (h_latch) begin
      h_total_d = h_meas;
      if (h_meas == h_total_q) begin
        if (stable_q != '1) stable_d = stable_q + SW'(1);
      end else begin
        stable_d = '0;
      end
    end else if (h_sat) begin
      h_total_d = '0;
      stable_d  = '0;
    end

    hlow_d = '0;
    if (!hs_s2_q) hlow_d = (hlow_q == '1) ? hlow_q : hlow_q + HW'(1);
    h_fell_d   = h_fell_q;
    h_sync_w_d = h_sync_w_q;
    if (hs_fall) h_fell_d = 1'b1;
    if (hs_rise && h_fell_q) begin
      h_sync_w_d = hlow_q;
      h_fell_d   = 1'b0;
    end

    // A line_start coinciding with frame_start counts as line 1 of the new frame
    vcnt_d = vcnt_q;
    if (frame_start_q) vcnt_d = line_start_q ? VW'(1) : '0;
    else if (line_start_q && vcnt_q != '1) vcnt_d = vcnt_q + VW'(1);
    v_seen_d  = v_seen_q | frame_start_q;
    v_total_d = v_total_q;
    v_prev_d  = v_prev_q;
    if (v_latch) begin
      v_total_d = vcnt_q;
      v_prev_d  = v_total_q;
    end

    vlow_d = '0;
    if (!vs_s2_q) vlow_d = (line_start_q && vlow_q != '1) ? vlow_q + VW'(1) : vlow_q;
    v_fell_d   = v_fell_q;
    v_sync_w_d = v_sync_w_q;
    if (vs_fall) v_fell_d = 1'b1;
    if (vs_rise && v_fell_q) begin
      v_sync_w_d = vlow_q;
      v_fell_d   = 1'b0;
    end

    locked_d = 1'b0;
    if (!h_sat) locked_d = (stable_q >= LOCK_TH) && (v_total_q == v_prev_q) && (v_total_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1_q       <= 1'b1;
      hs_s2_q       <= 1'b1;
      hs_s3_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
      vs_s2_q       <= 1'b1;
      vs_s3_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hcnt_q        <= '0;
      h_seen_q      <= 1'b0;
      h_total_q     <= '0;
      hlow_q        <= '0;
      h_fell_q      <= 1'b0;
      h_sync_w_q    <= '0;
      vcnt_q        <= '0;
      v_seen_q      <= 1'b0;
      v_total_q     <= '0;
      v_prev_q      <= '0;
      vlow_q        <= '0;
      v_fell_q      <= 1'b0;
      v_sync_w_q    <= '0;
      stable_q      <= '0;
      locked_q      <= 1'b0;
    end else begin
      hs_s1_q       <= vga_h_sync;
      hs_s2_q       <= hs_s1_q;
      hs_s3_q       <= hs_s2_q;
      vs_s1_q       <= vga_v_sync;
      vs_s2_q       <= vs_s1_q;
      vs_s3_q       <= vs_s2_q;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hcnt_q        <= hcnt_d;
      h_seen_q      <= h_seen_d;
      h_total_q     <= h_total_d;
      hlow_q        <= hlow_d;
      h_fell_q      <= h_fell_d;
      h_sync_w_q    <= h_sync_w_d;
      vcnt_q        <= vcnt_d;
      v_seen_q      <= v_seen_d;
      v_total_q     <= v_total_d;
      v_prev_q      <= v_prev_d;
      vlow_q        <= vlow_d;
      v_fell_q      <= v_fell_d;
      v_sync_w_q    <= v_sync_w_d;
      stable_q      <= stable_d;
      locked_q      <= locked_d;
    end
  end

`ifdef VGA_MON_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (locked_q && !locked_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign h_total     = h_total_q;
  assign h_sync_w    = h_sync_w_q;
  assign v_total     = v_total_q;
  assign v_sync_w    = v_sync_w_q;
  assign locked      = locked_q;

endmodule

// File: doc/vga_timing_monitor.md
VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 Parameter HW, default 12, width of horizontal counters in clocks.
REQ-002 Parameter VW, default 11, width of vertical counters in lines.
REQ-003 Parameter LOCK_LINES, default 4, consecutive equal line periods required for horizontal stability.
REQ-004 clk  input  1  pixel clock, the single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 vga_h_sync  input  1  horizontal sync, active-low, possibly asynchronous to clk.
REQ-007 vga_v_sync  input  1  vertical sync, active-low, possibly asynchronous to clk.
REQ-008 line_start  output  1  one-clk pulse per detected hsync assertion.
REQ-009 frame_start  output  1  one-clk pulse per detected vsync assertion.
REQ-010 h_total  output  HW  measured clocks per line; 0 = invalid.
REQ-011 h_sync_w  output  HW  measured hsync low width in clocks.
REQ-012 v_total  output  VW  measured lines per frame; 0 = invalid.
REQ-013 v_sync_w  output  VW  measured vsync low width in lines.
REQ-014 locked  output  1  timing stable.
REQ-015 err_cnt  output  8  lock-loss count.

Function
REQ-016 Each sync input SHALL pass a 2-flop synchronizer; an assertion edge is synchronized high-to-low, a deassertion edge is low-to-high.
REQ-017 line_start/frame_start SHALL be registered and rise exactly 2 clk after the clk edge at which the input is first sampled low, for one clk.
REQ-018 hcnt SHALL count clocks since the last line_start, reset to 0 on line_start, and saturate at 2^HW-1.
REQ-019 On each line_start after the first since reset/timeout, h_total SHALL latch hcnt+1.
REQ-020 h_sync_w SHALL latch clocks of synchronized hsync low on each hsync deassertion edge that follows an observed assertion.
REQ-021 vcnt SHALL count line_start pulses since the last frame_start; a line_start coincident with frame_start belongs to the new frame (vcnt <= 1, else 0).
REQ-022 On each frame_start after the first, v_total SHALL latch the previous frame's line count.
REQ-023 v_sync_w SHALL latch, on vsync deassertion, the number of line_start pulses while synchronized vsync was low.
REQ-024 Horizontal stable counter SHALL increment (saturating) when a newly latched h_total equals the prior h_total, and clear otherwise.
REQ-025 locked SHALL be 1 iff stable count >= LOCK_LINES and the last two latched v_total values are equal and nonzero; first lock occurs at the third frame_start at the earliest.
REQ-026 locked SHALL fall the clk after any h_total or v_total latch that mismatches its predecessor.
REQ-027 Timeout: if hcnt saturates, h_total, stable count and locked SHALL clear, and the next line_start is treated as first.
REQ-028 Measurement arithmetic SHALL be unsigned and SHALL never wrap.

Reset
REQ-029 rst_n low SHALL immediately force all outputs and counters to 0 and synchronizer flops to 1 (deasserted), including mid-frame.
REQ-030 After reset release, no edge SHALL be detected until an input is sampled low.

Configuration
REQ-031 Macro VGA_MON_ERR_CNT_EN defined: err_cnt SHALL increment on each locked 1-to-0 transition, saturating at 255, cleared only by reset.
REQ-032 Macro VGA_MON_ERR_CNT_EN undefined: err_cnt SHALL be tied to 0 and no counter logic built.

Verification
REQ-033 Reset asserted -> every output 0; release with syncs high for 1000 clk -> no pulses.
REQ-034 Single hsync low pulse at sample edge N -> line_start high only at edge N+2, one clk wide.
REQ-035 Lines of 768 clk, hsync low 16 clk, vsync low for one line every 512 lines, both syncs asserted in the same clk -> after third frame_start: h_total=768, h_sync_w=16, v_total=512, v_sync_w=1, locked=1.
REQ-036 From locked, change line length to 800 -> locked=0 one clk after the 800 latch, h_total=800, err_cnt=1 with macro (0 without); relock after LOCK_LINES lines and two equal frames.
REQ-037 Hold hsync high 5000 clk while locked -> at hcnt 4095 h_total=0 and locked=0.
REQ-038 rst_n pulsed low mid-frame while locked -> outputs 0 asynchronously; relock requires full sequence of REQ-035.
